alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Fetch/execute control sequencer for a single-bus ALU datapath (T0..T5 Moore FSM).
// Define MEM_WAIT_EN to stall T1 until mem_ready; default build ignores mem_ready.
module alu_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         bus_data,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                md_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlow_in,
  output logic                zlow_out,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPCODE_W-1:0] alu_op
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5
  } state_t;

  state_t state_q, state_d;
  logic [4:0] opcode_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       fields_ok;
  logic       unused;

  assign unused = ^bus_data[14:0];

  assign fields_ok = (opcode_q >= 5'd3) && (opcode_q <= 5'd11)
                  && ({1'b0, ra_q} < 5'(NUM_REGS))
                  && ({1'b0, rb_q} < 5'(NUM_REGS))
                  && ({1'b0, rc_q} < 5'(NUM_REGS));

`ifdef MEM_WAIT_EN
  // Set while T1 is being held, so the one-shot strobes fire only once.
  logic t1_wait_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      t1_wait_q <= 1'b0;
    end else begin
      t1_wait_q <= (state_q == T1) && (state_d == T1);
    end
  end
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T2) begin
        opcode_q <= bus_data[31:27];
        ra_q     <= bus_data[26:23];
        rb_q     <= bus_data[22:19];
        rc_q     <= bus_data[18:15];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    illegal  = 1'b0;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    pc_in    = 1'b0;
    md_read  = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    zlow_in  = 1'b0;
    zlow_out = 1'b0;
    reg_out  = '0;
    reg_in   = '0;
    alu_op   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = T0;
      end
      T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        zlow_in = 1'b1;
        state_d = T1;
      end
      T1: begin
        md_read = 1'b1;
        mdr_in  = 1'b1;
`ifdef MEM_WAIT_EN
        zlow_out = !t1_wait_q;
        pc_in    = !t1_wait_q;
        if (mem_ready) state_d = T2;
`else
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        state_d  = T2;
`endif
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (!fields_ok) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          reg_out = NUM_REGS'(1) << rb_q;
          y_in    = 1'b1;
          state_d = T4;
        end
      end
      T4: begin
        reg_out = NUM_REGS'(1) << rc_q;
        alu_op  = OPCODE_W'(opcode_q);
        zlow_in = 1'b1;
        state_d = T5;
      end
      T5: begin
        zlow_out = 1'b1;
        reg_in   = NUM_REGS'(1) << ra_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a 16-register and an 8-register instance.
// Expected sequence results are queued at issue; a negedge monitor compares on done/illegal.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic        ill;
    logic [15:0] ro3;
    logic [15:0] ro4;
    logic [4:0]  op;
    logic [15:0] ri;
    logic [7:0]  lat;
  } exp_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        pc_in;
    logic        pc_out;
    logic        y_in;
    logic        zlow_in;
    logic [4:0]  alu_op;
    logic [15:0] reg_out;
    logic [15:0] reg_in;
  } obs_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        mem_ready;
  logic        start_v [2];
  logic [31:0] bus_v   [2];

  logic        busy0, done0, ill0;
  logic [10:0] str0;
  logic [15:0] ro0, ri0;
  logic [4:0]  op0;
  logic        busy1, done1, ill1;
  logic [10:0] str1;
  logic [7:0]  ro1, ri1;
  logic [4:0]  op1;

  obs_t o [2];
  exp_t q [2][$];
  exp_t e_m;

  int nvec = 0;
  int nmis = 0;

  int          cyc    [2];
  int          pcin   [2];
  logic [15:0] ro3    [2];
  logic [15:0] ro4    [2];
  logic [15:0] anyreg [2];
  logic [4:0]  op4    [2];

  always #5 clock = ~clock;

  alu_op_sequencer #(.NUM_REGS(16), .OPCODE_W(5)) dut16 (
    .clock(clock), .clear(clear), .start(start_v[0]),
    .mem_ready(mem_ready), .bus_data(bus_v[0]),
    .busy(busy0), .done(done0), .illegal(ill0),
    .pc_out(str0[0]), .mar_in(str0[1]), .inc_pc(str0[2]),
    .pc_in(str0[3]), .md_read(str0[4]), .mdr_in(str0[5]),
    .mdr_out(str0[6]), .ir_in(str0[7]), .y_in(str0[8]),
    .zlow_in(str0[9]), .zlow_out(str0[10]),
    .reg_out(ro0), .reg_in(ri0), .alu_op(op0)
  );

  alu_op_sequencer #(.NUM_REGS(8), .OPCODE_W(5)) dut8 (
    .clock(clock), .clear(clear), .start(start_v[1]),
    .mem_ready(mem_ready), .bus_data(bus_v[1]),
    .busy(busy1), .done(done1), .illegal(ill1),
    .pc_out(str1[0]), .mar_in(str1[1]), .inc_pc(str1[2]),
    .pc_in(str1[3]), .md_read(str1[4]), .mdr_in(str1[5]),
    .mdr_out(str1[6]), .ir_in(str1[7]), .y_in(str1[8]),
    .zlow_in(str1[9]), .zlow_out(str1[10]),
    .reg_out(ro1), .reg_in(ri1), .alu_op(op1)
  );

  assign o[0] = {busy0, done0, ill0, str0[3], str0[0], str0[8],
                 str0[9], op0, ro0, ri0};
  assign o[1] = {busy1, done1, ill1, str1[3], str1[0], str1[8],
                 str1[9], op1, 8'h00, ro1, 8'h00, ri1};

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic exp_t mk(input logic ill, input logic [15:0] r3,
                              input logic [15:0] r4, input logic [4:0] op,
                              input logic [15:0] ri, input logic [7:0] lat);
    mk = {ill, r3, r4, op, ri, lat};
  endfunction

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (o[d].busy) begin
        cyc[d]++;
        if (o[d].pc_in) pcin[d]++;
        if (o[d].y_in) ro3[d] = o[d].reg_out;
        if (o[d].zlow_in && !o[d].pc_out) begin
          ro4[d] = o[d].reg_out;
          op4[d] = o[d].alu_op;
        end
        anyreg[d] = anyreg[d] | o[d].reg_out | o[d].reg_in;
      end
      if (o[d].done || o[d].illegal) begin
        if (q[d].size() == 0) begin
          chk("unexpected_end", 32'd1, 32'd0);
        end else begin
          e_m = q[d].pop_front();
          chk("kind_illegal", 32'(o[d].illegal), 32'(e_m.ill));
          chk("latency", 32'(cyc[d]), 32'(e_m.lat));
          chk("pc_in_cycles", 32'(pcin[d]), 32'd1);
          if (e_m.ill) begin
            chk("no_reg_drive", 32'(anyreg[d]), 32'd0);
          end else begin
            chk("t3_reg_out", 32'(ro3[d]), 32'(e_m.ro3));
            chk("t4_reg_out", 32'(ro4[d]), 32'(e_m.ro4));
            chk("t4_alu_op", 32'(op4[d]), 32'(e_m.op));
            chk("t5_reg_in", 32'(o[d].reg_in), 32'(e_m.ri));
          end
        end
      end
      if (!o[d].busy || o[d].done || o[d].illegal) begin
        cyc[d]    = 0;
        pcin[d]   = 0;
        ro3[d]    = '0;
        ro4[d]    = '0;
        op4[d]    = '0;
        anyreg[d] = '0;
      end
    end
  end

  task automatic wait_idle(input int d);
    int n = 0;
    while (o[d].busy && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 40) chk("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic run(input int d, input logic [31:0] bus, input exp_t e);
    bus_v[d] = bus;
    q[d].push_back(e);
    start_v[d] = 1'b1;
    @(posedge clock); #1;
    start_v[d] = 1'b0;
    wait_idle(d);
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    clear = 1'b1;
    mem_ready = 1'b1;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    bus_v[0] = '0; bus_v[1] = '0;
    @(posedge clock); #1;
    chk("reset_out16", 32'({busy0, done0, ill0, str0, ro0, ri0, op0}), 32'd0);
    chk("reset_out8", 32'({busy1, done1, ill1, str1, ro1, ri1, op1}), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;

    // ROR R2,R2,R6
    run(0, 32'h5113_0000, mk(1'b0, 16'h0004, 16'h0040, 5'b01010, 16'h0004, 8'd6));
    // bad opcode 11111
    run(0, 32'hF800_0000, mk(1'b1, 16'h0, 16'h0, 5'b0, 16'h0, 8'd4));
    // ADD R1,R3,R5
    run(0, {5'b00011, 4'd1, 4'd3, 4'd5, 15'd0},
        mk(1'b0, 16'h0008, 16'h0020, 5'b00011, 16'h0002, 8'd6));
    // 8-register instance: ra=9 illegal, then OR R7,R6,R5
    run(1, {5'b00011, 4'd9, 4'd1, 4'd2, 15'd0},
        mk(1'b1, 16'h0, 16'h0, 5'b0, 16'h0, 8'd4));
    run(1, {5'b00110, 4'd7, 4'd6, 4'd5, 15'd0},
        mk(1'b0, 16'h0040, 16'h0020, 5'b00110, 16'h0080, 8'd6));

    // SHL R15,R0,R7 with memory held off for three T1 cycles
    bus_v[0] = {5'b01001, 4'd15, 4'd0, 4'd7, 15'd0};
`ifdef MEM_WAIT_EN
    q[0].push_back(mk(1'b0, 16'h0001, 16'h0080, 5'b01001, 16'h8000, 8'd9));
`else
    q[0].push_back(mk(1'b0, 16'h0001, 16'h0080, 5'b01001, 16'h8000, 8'd6));
`endif
    mem_ready = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    mem_ready = 1'b1;
    wait_idle(0);
    @(posedge clock); #1;

    // clear during T4 aborts, then SUB R4,R4,R4 runs normally
    bus_v[0] = {5'b00100, 4'd4, 4'd4, 4'd4, 15'd0};
    start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (op0 == 5'd0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reached_t4", 32'(op0), 32'b00100);
    clear = 1'b1;
    #1;
    chk("clear_outputs", 32'({done0, ill0, str0, ro0, ri0, op0}), 32'd0);
    chk("clear_busy", 32'(busy0), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_clear", 32'(busy0), 32'd0);
    run(0, {5'b00100, 4'd4, 4'd4, 4'd4, 15'd0},
        mk(1'b0, 16'h0010, 16'h0010, 5'b00100, 16'h0010, 8'd6));

    // start held high: AND R0,R1,R2 three times back to back
    bus_v[0] = {5'b00101, 4'd0, 4'd1, 4'd2, 15'd0};
    repeat (3) q[0].push_back(mk(1'b0, 16'h0002, 16'h0004, 5'b00101, 16'h0001, 8'd6));
    start_v[0] = 1'b1;
    n = 0;
    while (q[0].size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    start_v[0] = 1'b0;
    if (n >= 60) chk("timeout_b2b", 32'd1, 32'd0);
    repeat (10) begin
      @(posedge clock); #1;
    end
    chk("b2b_idle", 32'(busy0), 32'd0);
    chk("queues_drained", 32'(q[0].size() + q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
